// File: rtl/ascon_perm_engine_if.sv
// ASCON 320-bit state type and the start/ready/done handshake bundle
// that connects the permutation engine to the mode FSM.
package ascon_pack;
    typedef logic [4:0][63:0] type_state; // word index 0 is x0
endpackage

interface ascon_perm_engine_if;
    logic                  start_i;
    logic [3:0]            nb_rounds_i;
    ascon_pack::type_state state_i;
    ascon_pack::type_state state_o;
    logic                  ready_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output start_i, nb_rounds_i, state_i,
        input  state_o, ready_o, busy_o, done_o
    );

    modport slave (
        input  start_i, nb_rounds_i, state_i,
        output state_o, ready_o, busy_o, done_o
    );
endinterface

// File: rtl/ascon_perm_engine.sv
// Self-sequencing ASCON permutation (p12/p8/p6) with 1 or 2 rounds per clock
// and a start/ready/done handshake; the result is held until the next start.
module ascon_perm_engine #(
    parameter int unsigned UNROLL = 1
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    ascon_perm_engine_if.slave bus
);
    typedef logic [4:0][63:0] state_t;
    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [3:0] STEP = 4'(UNROLL);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("ascon_perm_engine: UNROLL must be 1 or 2");
    end

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic state_t round_f(input state_t s_in, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        state_t      s_out;
        x0 = s_in[0];
        x1 = s_in[1];
        x2 = s_in[2] ^ {56'h0, ~r, r};
        x3 = s_in[3];
        x4 = s_in[4];
        // bit-sliced 5-bit S-box over all 64 columns
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        s_out[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        s_out[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        s_out[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        s_out[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        s_out[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return s_out;
    endfunction

    fsm_t       fsm_q, fsm_d;
    state_t     st_q, st_d;
    state_t     src, r1, r2, res;
    logic [3:0] rnd_q, rnd_d;
    logic [3:0] start_rnd, r_base;
    logic       done_q, done_d;

    always_comb begin
        unique case (bus.nb_rounds_i)
            4'd6:    start_rnd = 4'd6;
            4'd8:    start_rnd = 4'd4;
            default: start_rnd = 4'd0;
        endcase
    end

    // The round datapath is shared between the start step (fed from state_i)
    // and the running steps (fed back from the state register).
    always_comb begin
        src    = (fsm_q == IDLE) ? bus.state_i : st_q;
        r_base = (fsm_q == IDLE) ? start_rnd : rnd_q;
        r1     = round_f(src, r_base);
        r2     = round_f(r1, r_base + 4'd1);
        res    = (UNROLL == 2) ? r2 : r1;
    end

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        rnd_d  = rnd_q;
        done_d = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (bus.start_i) begin
                    fsm_d = RUN;
                    st_d  = res;
                    rnd_d = r_base + STEP;
                end
            end
            RUN: begin
                st_d  = res;
                rnd_d = rnd_q + STEP;
                if (rnd_q + STEP >= 4'd12) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            rnd_q  <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            rnd_q  <= rnd_d;
            done_q <= done_d;
        end
    end

    assign bus.state_o = st_q;
    assign bus.ready_o = (fsm_q == IDLE);
    assign bus.busy_o  = (fsm_q == RUN);
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_ascon_perm_engine.sv
// Directed bench for ascon_perm_engine: UNROLL=1 and UNROLL=2 instances checked
// against a table-driven ASCON round model through a result scoreboard.
module tb_ascon_perm_engine;
    import ascon_pack::*;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    logic clock_i = 1'b0;
    logic resetb_i;
    always #5 clock_i = ~clock_i;

    ascon_perm_engine_if bus1 ();
    ascon_perm_engine_if bus2 ();

    ascon_perm_engine #(.UNROLL(1)) dut1 (.clock_i(clock_i), .resetb_i(resetb_i), .bus(bus1));
    ascon_perm_engine #(.UNROLL(2)) dut2 (.clock_i(clock_i), .resetb_i(resetb_i), .bus(bus2));

    int        n_checks = 0;
    int        n_pass   = 0;
    type_state q1 [$];
    type_state q2 [$];
    type_state cur_s0   [1:2];
    int        cur_r0   [1:2];
    type_state last_res [1:2];

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic type_state model_round(input type_state s, input int r);
        type_state  t;
        type_state  o;
        logic [4:0] col;
        logic [4:0] sb;
        logic [7:0] c;
        c = 8'hF0 - 8'(15 * r);
        s[2][7:0] = s[2][7:0] ^ c;
        for (int b = 0; b < 64; b++) begin
            col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            sb  = SBOX[col];
            for (int w = 0; w < 5; w++) t[w][b] = sb[4-w];
        end
        for (int w = 0; w < 5; w++) o[w] = t[w] ^ rr(t[w], ROT_A[w]) ^ rr(t[w], ROT_B[w]);
        return o;
    endfunction

    function automatic type_state model_partial(input type_state s, input int r0, input int k);
        for (int i = 0; i < k && r0 + i < 12; i++) s = model_round(s, r0 + i);
        return s;
    endfunction

    function automatic int first_round(input logic [3:0] nb);
        return (nb == 4'd6) ? 6 : (nb == 4'd8) ? 4 : 0;
    endfunction

    function automatic type_state get_st(input int u);
        return (u == 1) ? bus1.state_o : bus2.state_o;
    endfunction
    function automatic logic get_done(input int u);
        return (u == 1) ? bus1.done_o : bus2.done_o;
    endfunction
    function automatic logic get_ready(input int u);
        return (u == 1) ? bus1.ready_o : bus2.ready_o;
    endfunction
    function automatic logic get_busy(input int u);
        return (u == 1) ? bus1.busy_o : bus2.busy_o;
    endfunction

    task automatic drive(input int u, input logic st, input type_state s, input logic [3:0] nb);
        if (u == 1) begin
            bus1.start_i = st; bus1.state_i = s; bus1.nb_rounds_i = nb;
        end else begin
            bus2.start_i = st; bus2.state_i = s; bus2.nb_rounds_i = nb;
        end
    endtask

    task automatic check_state(input string tag, input type_state obs, input type_state exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Drives a start (called #1 after an edge) and checks the first step.
    task automatic launch(input int u, input type_state s, input logic [3:0] nb);
        int r0;
        r0 = first_round(nb);
        if (u == 1) q1.push_back(model_partial(s, r0, 12));
        else        q2.push_back(model_partial(s, r0, 12));
        cur_s0[u] = s;
        cur_r0[u] = r0;
        drive(u, 1'b1, s, nb);
        @(posedge clock_i); #1;
        drive(u, 1'b0, ~s, 4'd6);
        check_val($sformatf("u%0d_ready_after_start", u), 32'(get_ready(u)), 32'd0);
        check_val($sformatf("u%0d_busy_after_start", u), 32'(get_busy(u)), 32'd1);
        check_state($sformatf("u%0d_step1", u), get_st(u), model_partial(s, r0, u));
    endtask

    // Waits (bounded) for done, checking every intermediate state on the way.
    task automatic wait_done(input int u, input int lat, input int glitch);
        int        k;
        int        depth;
        type_state alt;
        type_state exp;
        alt = {5{64'hdeadbeefcafef00d}};
        k   = 1;
        while (get_done(u) !== 1'b1 && k < 40) begin
            if (k == glitch) drive(u, 1'b1, alt, 4'd6);
            @(posedge clock_i); #1;
            drive(u, 1'b0, alt, 4'd8);
            k++;
            check_state($sformatf("u%0d_step%0d", u, k), get_st(u),
                        model_partial(cur_s0[u], cur_r0[u], k * u));
        end
        check_val($sformatf("u%0d_latency", u), 32'(k), 32'(lat));
        check_val($sformatf("u%0d_ready_in_done", u), 32'(get_ready(u)), 32'd1);
        check_val($sformatf("u%0d_busy_in_done", u), 32'(get_busy(u)), 32'd0);
        depth = (u == 1) ? q1.size() : q2.size();
        check_val($sformatf("u%0d_scoreboard_depth", u), 32'(depth), 32'd1);
        if (depth > 0) begin
            exp = (u == 1) ? q1.pop_front() : q2.pop_front();
            last_res[u] = exp;
            check_state($sformatf("u%0d_result", u), get_st(u), exp);
        end
    endtask

    task automatic hold_check(input int u);
        @(posedge clock_i); #1;
        check_val($sformatf("u%0d_done_cleared", u), 32'(get_done(u)), 32'd0);
        check_val($sformatf("u%0d_ready_idle", u), 32'(get_ready(u)), 32'd1);
        check_state($sformatf("u%0d_result_hold", u), get_st(u), last_res[u]);
    endtask

    initial begin
        type_state vec;
        type_state vec2;
        vec[0] = 64'h80400c0600000000;
        vec[1] = 64'h0001020304050607;
        vec[2] = 64'h08090a0b0c0d0e0f;
        vec[3] = 64'h0011223344556677;
        vec[4] = 64'h8899aabbccddeeff;
        for (int w = 0; w < 5; w++) vec2[w] = vec[w] ^ {8{8'(8'h11 * (w + 1))}};

        resetb_i = 1'b0;
        drive(1, 1'b0, '0, 4'd0);
        drive(2, 1'b0, '0, 4'd0);
        repeat (2) @(posedge clock_i);
        #1;
        for (int u = 1; u <= 2; u++) begin
            check_state($sformatf("u%0d_reset_state", u), get_st(u), '0);
            check_val($sformatf("u%0d_reset_ready", u), 32'(get_ready(u)), 32'd1);
            check_val($sformatf("u%0d_reset_busy", u), 32'(get_busy(u)), 32'd0);
            check_val($sformatf("u%0d_reset_done", u), 32'(get_done(u)), 32'd0);
        end
        resetb_i = 1'b1;

        // asynchronous reset in the middle of a p12 run
        drive(1, 1'b1, vec, 4'd12);
        @(posedge clock_i); #1;
        drive(1, 1'b0, vec, 4'd12);
        repeat (3) @(posedge clock_i);
        #3;
        check_val("midrun_busy_before_reset", 32'(bus1.busy_o), 32'd1);
        resetb_i = 1'b0;
        #1;
        check_state("midrun_reset_state", bus1.state_o, '0);
        check_val("midrun_reset_ready", 32'(bus1.ready_o), 32'd1);
        check_val("midrun_reset_busy", 32'(bus1.busy_o), 32'd0);
        @(posedge clock_i); #1;
        check_val("midrun_reset_no_done", 32'(bus1.done_o), 32'd0);
        resetb_i = 1'b1;
        @(posedge clock_i); #1;
        check_val("midrun_after_release_done", 32'(bus1.done_o), 32'd0);
        check_val("midrun_after_release_ready", 32'(bus1.ready_o), 32'd1);

        // p12 / p6 / p8 on both unroll factors
        launch(1, vec, 4'd12); wait_done(1, 12, 0); hold_check(1);
        launch(1, vec, 4'd6);  wait_done(1, 6, 0);  hold_check(1);
        launch(1, vec, 4'd8);  wait_done(1, 8, 0);  hold_check(1);
        launch(2, vec, 4'd12); wait_done(2, 6, 0);  hold_check(2);
        launch(2, vec, 4'd6);  wait_done(2, 3, 0);  hold_check(2);
        launch(2, vec, 4'd8);  wait_done(2, 4, 0);  hold_check(2);

        // start pulse with different data while running is ignored
        launch(1, vec, 4'd12); wait_done(1, 12, 3); hold_check(1);
        launch(2, vec2, 4'd12); wait_done(2, 6, 2); hold_check(2);

        // start accepted in the done cycle, back to back
        launch(1, vec, 4'd12); wait_done(1, 12, 0);
        launch(1, vec2, 4'd8); wait_done(1, 8, 0); hold_check(1);
        launch(2, vec, 4'd6);  wait_done(2, 3, 0);
        launch(2, vec2, 4'd12); wait_done(2, 6, 0); hold_check(2);

        // unsupported round count falls back to p12
        launch(1, vec2, 4'd5); wait_done(1, 12, 0); hold_check(1);
        launch(2, vec2, 4'd5); wait_done(2, 6, 0);  hold_check(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ascon_perm_engine.md
# ascon_perm_engine

Self-sequencing ASCON permutation engine for the ASCON datapath, built on `ascon_pack::type_state`. It generalises the externally driven single-round permutation: it owns its round counter, runs a programmable round count (p12 / p8 / p6), and can unroll 1 or 2 rounds per clock. It talks to the mode FSM through a start/ready/done handshake and holds its result until the next start.

## Interface
- `UNROLL`, default 1: rounds computed per clock. Legal values are 1 and 2; any other value is a elaboration error.
- `clock_i`  in  1  system clock, rising edge.
- `resetb_i`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  start request. Sampled only when `ready_o`=1.
- `nb_rounds_i`  in  4  round count, sampled with `start_i`. 6 selects p6, 8 selects p8, any other value selects p12.
- `state_i`  in  type_state (5×64)  permutation input, sampled with `start_i`.
- `state_o`  out  type_state  permutation state register. Holds the final result after `done_o`.
- `ready_o`  out  1  engine idle; a start will be accepted.
- `busy_o`  out  1  permutation in progress.
- `done_o`  out  1  one-cycle pulse: `state_o` is valid.

## Operation
- **Single round `R(S, r)`**, applied in this order:
  - Constant addition: `x2 ^= {56'h0, ~r[3:0], r[3:0]}`. Examples: r=0 gives F0, r=4 gives B4, r=6 gives 96, r=11 gives 4B.
  - Substitution: 5-bit ASCON S-box applied bit-sliced over the 64 columns.
  - Linear diffusion, rotate-right amounts: x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41). Each word becomes `xi ^ ror(xi,a) ^ ror(xi,b)`.
- **Round count:** N = 6, 8 or 12, decoded from `nb_rounds_i`. Round indices run from r = 12−N to 11.
- **Unrolling:** with UNROLL=2 the two rounds are chained combinationally within the cycle, using r and r+1.
- **FSM states:** IDLE and RUN.
  - IDLE to RUN on `start_i`=1. On that same edge:
    - `state_o` ← R^UNROLL(`state_i`, starting at r=12−N).
    - `rnd_q` ← 12−N+UNROLL.
  - RUN, while `rnd_q`+UNROLL < 12: `state_o` ← R^UNROLL(`state_o`, `rnd_q`) and `rnd_q` += UNROLL.
  - RUN to IDLE on the edge that applies the final round(s), when `rnd_q`+UNROLL = 12. `done_o` is registered to 1 on that edge.
- **Outputs:** `ready_o` = (state == IDLE). `busy_o` = (state == RUN).
- **Width rules:** `rnd_q` is 4 bits, with range 0..12; it never exceeds 12. N and UNROLL are always even-compatible (6, 8 and 12 are all divisible by 1 and 2), so no partial final step exists.
- **Boundary conditions:**
  - `start_i` while in RUN is ignored. State, counter and result are unaffected.
  - `start_i` in the `done_o` cycle is accepted, because `ready_o` is already 1. This gives back-to-back permutations with no bubble, and `done_o` still pulses for the previous result.
  - `nb_rounds_i` and `state_i` changing during RUN have no effect.
  - Reset asserted mid-permutation aborts immediately to the reset values. No `done_o` is produced.

## Timing
- **Reset values:**
  - `state_o` = all five words 0.
  - `ready_o`=1, `busy_o`=0, `done_o`=0.
  - Internal: `rnd_q`=0, FSM in IDLE.
- **Latency:** L = N/UNROLL clock edges. The start edge is edge 1.
  - UNROLL=1: p12 L=12, p8 L=8, p6 L=6.
  - UNROLL=2: p12 L=6, p8 L=4, p6 L=3.
- **After the start edge:** `busy_o`=1 and `ready_o`=0 for L−1 cycles.
- **After edge L:** `done_o`=1, `ready_o`=1 and `busy_o`=0 for exactly one cycle. `done_o` then returns to 0.
- **Result hold:** `state_o` is stable from edge L until the next accepted start.
- **Combinational paths:** no output is a combinational function of the inputs; all outputs are registered or decoded from state only.
- **Critical path:** UNROLL rounds of logic between `state_o`/`state_i` and `state_o`.

## Test plan
1. **Reset mid-run.** Drive `resetb_i`=0 during a p12 run, asynchronously between clock edges. Required: `state_o`=0, `ready_o`=1 and `busy_o`=0 immediately, without waiting for a clock edge. No `done_o` pulse.
2. **p12, UNROLL=1.** Start with `state_i` = {80400c0600000000, 0001020304050607, 08090a0b0c0d0e0f, 0011223344556677, 8899aabbccddeeff}, `nb_rounds_i`=12. Required:
   - `done_o` pulses 12 edges after the start edge.
   - `state_o` equals the golden model's p12 output.
   - Per-cycle intermediate states match the golden model with constants F0, E1, …, 4B.
3. **p6 and p8.** Same input with `nb_rounds_i`=6, then 8. Required: `done_o` after 6 and 8 edges respectively. The first constants applied are 96 and B4; the outputs match the golden model.
4. **UNROLL=2 equivalence.** Run the same stimuli as scenarios 2 and 3 on an UNROLL=2 instance. Required: bit-identical results, with `done_o` after 6, 3 and 4 edges respectively.
5. **Handshake boundaries.** Three sub-cases:
   - Pulse `start_i` with a different `state_i` during RUN. Required: the result is unchanged.
   - Assert `start_i` in the `done_o` cycle. Required: the new permutation is accepted, `ready_o` drops the next cycle, and the previous result was visible during the `done_o` cycle.
   - `nb_rounds_i`=5. Required: behaves as p12, with L=12.
